// File: rtl/mem_responder.sv
// Tagged memory responder: allocates a 4-bit tag per accepted LOAD/STORE and returns
// {tag, data} exactly LATENCY cycles later, in accept order.
module mem_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_LINES = 4096,
  parameter int LATENCY   = 8,
  parameter int NUM_TAGS  = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);

  localparam int         AW        = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic [63:0]         mem [MEM_LINES];
  logic [63:0]         rd_data_reg;
  logic [3:0]          tag_reg  [LATENCY];
  logic [63:0]         data_reg [LATENCY];
  logic                load_reg;
  logic [NUM_TAGS-1:0] free_reg, free_next;
  logic                in_range, accept, accept_load, accept_store;
  logic [3:0]          alloc_tag;
  logic [63:0]         stage0_data;
  logic [AW-1:0]       word_idx;
  logic                unused_addr_bits;

  assign unused_addr_bits = &{1'b0, proc2mem_addr[2:0]};
  assign word_idx     = proc2mem_addr[3 +: AW];
  assign in_range     = {3'b000, proc2mem_addr[XLEN-1:3]} < XLEN'(MEM_LINES);
  assign accept       = (proc2mem_command == BUS_LOAD || proc2mem_command == BUS_STORE)
                        && in_range && (|free_reg);
  assign accept_load  = accept && (proc2mem_command == BUS_LOAD);
  assign accept_store = accept && (proc2mem_command == BUS_STORE);
  assign mem2proc_response = accept ? alloc_tag : 4'd0;

  // Lowest-numbered free tag; bit i of free_reg stands for tag i+1.
  always_comb begin
    alloc_tag = 4'd0;
    for (int i = NUM_TAGS - 1; i >= 0; i--)
      if (free_reg[i]) alloc_tag = 4'(i + 1);
  end

  // A completing tag is released at the end of its output cycle, never reused within it.
  always_comb begin
    free_next = free_reg;
    if (mem2proc_tag != 4'd0) free_next[mem2proc_tag - 4'd1] = 1'b1;
    if (accept)               free_next[alloc_tag - 4'd1]    = 1'b0;
  end

  // Backing store has no reset; the load snapshot is taken at the accept edge.
  always_ff @(posedge clock) begin
    if (accept_store) mem[word_idx] <= proc2mem_data;
    if (accept_load)  rd_data_reg   <= mem[word_idx];
  end

  // Stage 0 holds store data or a pending load; the load snapshot merges in on the way to stage 1.
  assign stage0_data = load_reg ? rd_data_reg : data_reg[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_reg <= '1;
      load_reg <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_reg[i]  <= 4'd0;
        data_reg[i] <= 64'd0;
      end
    end else begin
      free_reg    <= free_next;
      load_reg    <= accept_load;
      tag_reg[0]  <= mem2proc_response;
      data_reg[0] <= accept_store ? proc2mem_data : 64'd0;
      for (int i = 1; i < LATENCY; i++) begin
        tag_reg[i]  <= tag_reg[i-1];
        data_reg[i] <= (i == 1) ? stage0_data : data_reg[i-1];
      end
    end
  end

  assign mem2proc_tag = tag_reg[LATENCY-1];

  if (LATENCY == 1) begin : g_direct
    assign mem2proc_data = stage0_data;
  end else begin : g_piped
    assign mem2proc_data = data_reg[LATENCY-1];
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Tagged memory responder: the far end of the BUS_LOAD/BUS_STORE tag protocol that the instruction and data caches use as initiators.
- Accepts one command per cycle and returns an allocated 4-bit transaction tag combinationally in the same cycle.
- Returns the completed transaction's tag plus 64-bit data exactly LATENCY cycles later.
- Used as the synthesizable memory model behind cache L2 blocks and in the cache testbenches.

Parameters:
- XLEN, 32, address width.
- MEM_LINES, 4096, number of 64-bit words of backing storage.
- LATENCY, 8, cycles from accept to completion; legal range 1..64.
- NUM_TAGS, 15, live tags 1..NUM_TAGS; tag 0 means "none".

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- proc2mem_command  in  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; value 3 is treated as BUS_NONE.
- proc2mem_addr  in  XLEN  byte address; [2:0] ignored; word index = addr[XLEN-1:3].
- proc2mem_data  in  64  store data.
- mem2proc_response  out  4  combinational; tag allocated this cycle, 0 = rejected.
- mem2proc_data  out  64  registered; completion data, 0 when mem2proc_tag is 0.
- mem2proc_tag  out  4  registered; completing tag, 0 = no completion.

Behaviour:
- Accept condition: command is LOAD or STORE, word index < MEM_LINES, and at least one tag is free at the start of the cycle.
  - mem2proc_response = lowest-numbered free tag when the accept condition holds, else 0.
  - A rejected command has no side effects; the initiator must re-issue it.
- Free vector: NUM_TAGS bits, all free at reset.
  - Allocation clears the bit at the accept edge.
  - A tag completing in cycle C is freed at the end of C and is allocatable from C+1, never in C itself.
- LOAD: the word is read at the accept edge (snapshot), and that data is returned at completion.
- STORE: the memory word is written at the accept edge. Completion still occurs with mem2proc_data = the stored value.
- Ordering: a STORE accepted after a LOAD to the same word does not change that LOAD's data. A LOAD accepted after a STORE sees the new value.
- Pipeline: LATENCY-stage shift register of {valid, tag, data}, advanced every cycle.
  - Command accepted in cycle N → mem2proc_tag/mem2proc_data show it during cycle N+LATENCY, for exactly one cycle.
  - Completions come out in accept order, at most one per cycle.
  - There is no stall or backpressure; the initiator must capture completions when they appear.
- Tag exhaustion is possible only when LATENCY >= NUM_TAGS. While exhausted, response = 0.
- Reset asserted (low), asynchronously and at any time including mid-flight:
  - All pipeline valids, both outputs and the free vector clear immediately.
  - In-flight transactions are dropped.
  - Memory contents are not reset.
  - After reset release, the first accepted command gets tag 1.
- Memory array has no reset and is uninitialised. Benches preload it via STORE commands.

Test Plan:
1. Reset release; STORE addr 0x100 data 0xDEADBEEF_CAFEF00D in cycle N, LOAD 0x100 in N+1 → responses 1 then 2; tag 1 completes at N+8 with the stored value; tag 2 at N+9 with 0xDEADBEEF_CAFEF00D.
2. LOADs of 0x0, 0x8, 0x10, 0x18 (preloaded 0xA..0xD) in consecutive cycles N..N+3 → responses 1, 2, 3, 4; completions tag 1..4 with data 0xA..0xD in cycles N+8..N+11; mem2proc_tag is 0 in N+12.
3. LATENCY=20; 16 LOADs in consecutive cycles from N → responses 1..15, then 0 in N+15. Re-issued LOAD held every cycle → response 0 through N+20 and tag 1 in N+21, when tag 1 is allocatable again.
4. LOAD at addr MEM_LINES*8 and command 3 → response 0; no completion ever appears; free vector unchanged.
5. Assert reset mid-cycle at N+4 with 4 LOADs in flight → mem2proc_tag/mem2proc_data become 0 before the next edge. After release, no stale completions appear, and the next LOAD gets response 1.
6. LOAD 0x200 (old 0x11) in N, STORE 0x200 data 0x22 in N+1, LOAD 0x200 in N+2 → completions carry 0x11, 0x22, 0x22.
